// File: rtl/unsigned_seq_div_restoring_pkg.sv
// Shared definitions for the unsigned sequential restoring divider:
// FSM state encoding, default operand width and a counter-width helper.
package unsigned_seq_div_restoring_pkg;

    // Default width of dividend, divisor, quotient and remainder.
    localparam int DIV_WIDTH_DEFAULT = 6;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The step counter has to reach N-1. Keep it at least one bit wide so a
    // degenerate N=1 build still has a legal vector.
    function automatic int step_count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unsigned_seq_div_restoring_step.sv
// div_restore_step: one combinational restoring-division iteration.
// The partial remainder is shifted left, pulling in the quotient register's
// top bit. The divisor is subtracted only when it fits; otherwise the
// shifted value is kept unchanged (the "restore"). The comparison result
// becomes the new quotient LSB.
module div_restore_step #(
    parameter int N = 6
) (
    input  logic [N:0]   p,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N:0]   p_next,
    output logic [N-1:0] q_next
);

    logic [N:0] p_shift;
    logic [N:0] d_ext;
    logic       fits;

    // Shift, trial-compare and conditionally subtract. The partial remainder
    // is always below the divisor before the shift, so 2*P+1 < 2*D stays
    // inside N+1 bits and the subtraction can never underflow when taken.
    always_comb begin
        p_shift = (p << 1) | (N+1)'(q[N-1]);
        d_ext   = {1'b0, d};
        fits    = (p_shift >= d_ext);
        p_next  = fits ? (p_shift - d_ext) : p_shift;
        q_next  = (q << 1) | N'(fits);
    end

endmodule

// File: rtl/unsigned_seq_div_restoring.sv
// unsigned_seq_div_restoring: N-bit unsigned restoring divider, one quotient
// bit per clock. load captures the operands and (re)starts a division; the
// result appears exactly N edges later with done held high until the next
// load or rst. busy is high exactly while the FSM is in RUN.
//
// Optional feature: define DIVZERO_DETECT_EN to add the dbz output. With it,
// a load with a zero divisor skips RUN and reports quotient = all ones and
// remainder = dividend after a single edge. Without it, a zero divisor runs
// the normal N steps, which naturally produce the same result values.
module unsigned_seq_div_restoring
    import unsigned_seq_div_restoring_pkg::*;
#(
    parameter int N = DIV_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done
`ifdef DIVZERO_DETECT_EN
    ,
    output logic         dbz
`endif
);

    localparam int             CW        = step_count_width(N);
    localparam logic [CW-1:0]  LAST_STEP = CW'(N - 1);

    div_state_t    state_reg;
    logic [N:0]    p_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    logic [CW-1:0] cnt_reg;

    logic [N:0]    p_next;
    logic [N-1:0]  q_next;

    // Single restoring iteration applied to the current working registers.
    div_restore_step #(
        .N (N)
    ) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (p_next),
        .q_next (q_next)
    );

    // busy is a pure decode of the registered state, so it tracks RUN exactly.
    assign busy = (state_reg == RUN);

    // Controller, datapath registers and result registers. load wins over a
    // RUN step on the same edge, which gives both abort-and-restart and the
    // "held load keeps restarting" behaviour for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt_reg   <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
`ifdef DIVZERO_DETECT_EN
            dbz       <= 1'b0;
`endif
        end else if (load) begin
            q_reg   <= dividend;
            d_reg   <= divisor;
            p_reg   <= '0;
            cnt_reg <= '0;
`ifdef DIVZERO_DETECT_EN
            if (divisor == '0) begin
                // Short-circuit: the result of dividing by zero is known
                // without iterating, so report it straight away.
                state_reg <= DONE;
                quotient  <= '1;
                remainder <= dividend;
                done      <= 1'b1;
                dbz       <= 1'b1;
            end else begin
                state_reg <= RUN;
                quotient  <= '0;
                remainder <= '0;
                done      <= 1'b0;
                dbz       <= 1'b0;
            end
`else
            state_reg <= RUN;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                RUN: begin
                    p_reg   <= p_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_STEP) begin
                        // The final step's outputs go straight to the
                        // result registers so they are valid on this edge.
                        state_reg <= DONE;
                        quotient  <= q_next;
                        remainder <= p_next[N-1:0];
                        done      <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE hold everything until the next load.
                    state_reg <= state_reg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_seq_div_restoring.sv
// Directed self-checking bench for unsigned_seq_div_restoring (N=6).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Also builds with DIVZERO_DETECT_EN defined, in which case dbz is checked.
module tb_unsigned_seq_div_restoring;

    localparam int N = 6;

    logic         clk;
    logic         rst;
    logic         load;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
`ifdef DIVZERO_DETECT_EN
    logic         dbz;
`endif

    int checks = 0;
    int passed = 0;

    unsigned_seq_div_restoring #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
`ifdef DIVZERO_DETECT_EN
        ,
        .dbz       (dbz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done rises or the budget runs out; e counts edges after
    // the load edge, busy_cnt counts samples with busy high before done.
    task automatic wait_done(output int e, output int busy_cnt);
        e = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && e < N + 4) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            e++;
        end
    endtask

    // One division: load, check latency, busy span and result, then check
    // the result holds one more cycle.
    task automatic test_vector(input int a, input int b, input int exp_q,
                               input int exp_r, input int exp_lat,
                               input string name);
        int e;
        int bc;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        eq = exp_q[N-1:0];
        er = exp_r[N-1:0];
        load = 1'b1;
        dividend = a[N-1:0];
        divisor = b[N-1:0];
        tick();
        load = 1'b0;
        if (exp_lat > 0) begin
            checks++;
            if (done !== 1'b0) $display("FAIL %s done_after_load %0d/%0d: got %b want 0", name, a, b, done);
            else passed++;
        end
        wait_done(e, bc);
        checks++;
        if (e !== exp_lat) $display("FAIL %s latency %0d/%0d: got %0d want %0d", name, a, b, e, exp_lat);
        else passed++;
        checks++;
        if (bc !== exp_lat) $display("FAIL %s busy_cycles %0d/%0d: got %0d want %0d", name, a, b, bc, exp_lat);
        else passed++;
        checks++;
        if (quotient !== eq || remainder !== er || busy !== 1'b0)
            $display("FAIL %s result %0d/%0d: got q=%0d r=%0d busy=%b want q=%0d r=%0d busy=0",
                     name, a, b, quotient, remainder, busy, eq, er);
        else passed++;
        tick();
        checks++;
        if (done !== 1'b1 || quotient !== eq || remainder !== er)
            $display("FAIL %s hold %0d/%0d: got done=%b q=%0d r=%0d want done=1 q=%0d r=%0d",
                     name, a, b, done, quotient, remainder, eq, er);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b0;
        dividend = '0;
        divisor = '0;
        #3;
        checks++;
        if (quotient !== '0 || remainder !== '0 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_state: got q=%0d r=%0d done=%b busy=%b want all 0",
                     quotient, remainder, done, busy);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_basic();
        test_vector(45, 7, 6, 3, N, "basic");
`ifdef DIVZERO_DETECT_EN
        checks++;
        if (dbz !== 1'b0) $display("FAIL basic_dbz: got %b want 0", dbz);
        else passed++;
`endif
    endtask

    task automatic test_boundaries();
        test_vector(63, 1, 63, 0, N, "max_by_one");
        test_vector(5, 9, 0, 5, N, "small_by_big");
        test_vector(0, 5, 0, 0, N, "zero_dividend");
        test_vector(63, 63, 1, 0, N, "equal_max");
    endtask

    task automatic test_divzero();
`ifdef DIVZERO_DETECT_EN
        test_vector(13, 0, 63, 13, 0, "divzero");
        checks++;
        if (dbz !== 1'b1) $display("FAIL divzero_dbz: got %b want 1", dbz);
        else passed++;
        test_vector(20, 3, 6, 2, N, "dbz_cleared");
        checks++;
        if (dbz !== 1'b0) $display("FAIL dbz_cleared_flag: got %b want 0", dbz);
        else passed++;
`else
        test_vector(13, 0, 63, 13, N, "divzero");
`endif
    endtask

    task automatic test_restart();
        int e;
        int bc;
        load = 1'b1;
        dividend = 6'd45;
        divisor = 6'd7;
        tick();
        load = 1'b0;
        tick();
        tick();
        load = 1'b1;
        dividend = 6'd20;
        divisor = 6'd3;
        tick();
        load = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL restart_reload: got busy=%b done=%b want 1 0", busy, done);
        else passed++;
        wait_done(e, bc);
        checks++;
        if (e !== N) $display("FAIL restart_latency: got %0d want %0d", e, N);
        else passed++;
        checks++;
        if (quotient !== 6'd6 || remainder !== 6'd2)
            $display("FAIL restart_result: got q=%0d r=%0d want q=6 r=2", quotient, remainder);
        else passed++;
    endtask

    task automatic test_held_load();
        int e;
        int bc;
        load = 1'b1;
        dividend = 6'd50;
        divisor = 6'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL held_load_busy cycle %0d: got busy=%b done=%b want 1 0", i, busy, done);
            else passed++;
        end
        load = 1'b0;
        wait_done(e, bc);
        checks++;
        if (e !== N || quotient !== 6'd6 || remainder !== 6'd2)
            $display("FAIL held_load_result: got lat=%0d q=%0d r=%0d want lat=%0d q=6 r=2",
                     e, quotient, remainder, N);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int seen;
        load = 1'b1;
        dividend = 6'd45;
        divisor = 6'd7;
        tick();
        load = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0)
            $display("FAIL reset_mid_run: got busy=%b done=%b q=%0d r=%0d want all 0",
                     busy, done, quotient, remainder);
        else passed++;
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL reset_mid_no_done: got %0d active cycles want 0", seen);
        else passed++;
        test_vector(50, 8, 6, 2, N, "after_reset");
        // The result registers must also clear asynchronously from DONE.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || quotient !== '0 || remainder !== '0)
            $display("FAIL reset_in_done: got done=%b q=%0d r=%0d want all 0", done, quotient, remainder);
        else passed++;
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        int a;
        int b;
        for (int x = 0; x < (1 << N); x++) begin
            for (int y = 1; y < (1 << N); y++) begin
                test_vector(x, y, x / y, x % y, N, "sweep");
            end
        end
        for (int k = 0; k < 200; k++) begin
            a = int'($urandom_range(63, 0));
            b = int'($urandom_range(63, 1));
            test_vector(a, b, a / b, a % b, N, "random");
            checks++;
            if (int'(quotient) * b + int'(remainder) !== a || int'(remainder) >= b)
                $display("FAIL random_invariant %0d/%0d: got q=%0d r=%0d", a, b, quotient, remainder);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_divzero();
        test_restart();
        test_held_load();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/unsigned_seq_div_restoring.md
UNSIGNED_SEQ_DIV_RESTORING -- requirements
Module: unsigned_seq_div_restoring

Interface
REQ-001 The block SHALL have parameter N, default 6, giving the dividend, divisor, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port load, input, 1 bit: capture operands and start a division.
REQ-005 The block SHALL have port dividend, input, N bits: unsigned numerator.
REQ-006 The block SHALL have port divisor, input, N bits: unsigned denominator.
REQ-007 The block SHALL have port quotient, output reg, N bits: result quotient.
REQ-008 The block SHALL have port remainder, output reg, N bits: result remainder.
REQ-009 The block SHALL have port busy, output, 1 bit: division in progress.
REQ-010 The block SHALL have port done, output reg, 1 bit: result valid, held until the next load or rst.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; rst forces IDLE.
REQ-012 Transitions SHALL be:
- load in any state -> RUN;
- RUN with step counter = N-1 -> DONE;
- otherwise the FSM holds its state.
REQ-013 On a load edge the block SHALL:
- latch dividend into the quotient shift register and divisor into a divisor register;
- clear the N+1-bit partial remainder;
- clear the step counter, quotient, remainder and done.
REQ-014 Each RUN cycle SHALL do one restoring step:
- P = {P[N-1:0], Q[N-1]} and Q = Q << 1;
- if P >= {0, D}, then P = P - D and Q[0] = 1, else P is restored and Q[0] = 0;
- increment the step counter.
REQ-015 Arithmetic SHALL be unsigned, N+1 bits wide for the partial remainder, with no overflow possible.
REQ-016 Latency SHALL be exactly N RUN cycles: with load sampled at edge k, done=1 and the outputs are valid after edge k+N.
REQ-017 On entering DONE, quotient SHALL take Q and remainder SHALL take P[N-1:0]; both SHALL be stable while in DONE.
REQ-018 busy SHALL equal 1 exactly while the state is RUN.
REQ-019 A load asserted during RUN SHALL abort the current division and restart it with the new operands, with no result and no done pulse for the aborted operation.
REQ-020 Load SHALL take priority over a RUN step on the same edge.
REQ-021 A held load SHALL keep restarting the division; computation SHALL begin on the first edge after load deasserts.
REQ-022 With DIVZERO_DETECT_EN undefined, divisor = 0 SHALL run the normal N cycles and yield quotient = all ones and remainder = dividend.
REQ-023 In the invariant for every nonzero divisor, dividend SHALL equal quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-024 On rst assertion, without waiting for clk, the block SHALL:
- go to state IDLE;
- clear quotient, remainder, done, busy, the step counter and all internal registers.
REQ-025 An rst during RUN SHALL abandon the operation; no done SHALL follow.
REQ-026 The first load after rst deassertion SHALL operate normally.

Configuration
REQ-027 Macro DIVZERO_DETECT_EN SHALL control divide-by-zero detection.
REQ-028 When DIVZERO_DETECT_EN is defined, the block SHALL:
- add output dbz, 1 bit, cleared by rst and load;
- on a load with divisor = 0, skip RUN and go straight to DONE after one edge, with dbz=1, quotient = all ones and remainder = dividend.
REQ-029 When DIVZERO_DETECT_EN is undefined, the dbz port and its logic SHALL be absent, and REQ-022 SHALL apply.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default width constant, 6.
REQ-031 A combinational sub-module div_restore_step (inputs P, Q, D; outputs next P, next Q) SHALL implement REQ-014.
REQ-032 The top level SHALL hold the FSM, the counter and the output registers.

Verification (N=6)
REQ-033 A bench SHALL check: load 45/7 -> after 6 edges done=1, quotient=6, remainder=3; busy=1 for exactly 6 cycles.
REQ-034 A bench SHALL check the boundaries: 63/1 -> 63 r 0; 5/9 -> 0 r 5; 0/5 -> 0 r 0; 63/63 -> 1 r 0.
REQ-035 A bench SHALL check 13/0:
- without the macro, after 6 edges, quotient=63, remainder=13;
- with the macro, after 1 edge, done=1, dbz=1, quotient=63, remainder=13.
REQ-036 A bench SHALL check restart: load 45/7, then load 20/3 at the third RUN cycle -> a single done 6 edges after the second load, with quotient=6 and remainder=2.
REQ-037 A bench SHALL check reset mid-operation: rst asserted between edges during RUN -> outputs 0 immediately, no done; a subsequent load 50/8 -> 6 r 2.
REQ-038 A bench SHALL run random sweeps of all operand pairs against REQ-023.
